// File: rtl/perf_counter_unit.sv
// Performance counters for cycles, retired instructions, cache requests/hits and stalls,
// with a run/pause/halt state machine and a one-cycle-latency readout port.
module perf_counter_unit #(
    parameter int CNT_W = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             retire_regwrite,
    input  logic             retire_memwrite,
    input  logic             halt,
    input  logic             stall,
    input  logic             icache_req,
    input  logic             icache_hit,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    input  logic             rd_en,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [1:0]       state,
    output logic             halted
);

    localparam int NUM_CNT = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_q, ovf_d;
    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]   sel_val;
    logic [CNT_W-1:0]   status_val;
    logic [9:0]         status_raw;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = enable ? ST_RUN : ST_IDLE;
                ST_RUN: begin
                    if (halt)
                        state_d = ST_HALTED;
                    else if (!enable)
                        state_d = ST_IDLE;
                    else
                        state_d = ST_RUN;
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_IDLE;
            endcase
        end
        halted_d = (state_d == ST_HALTED);
    end

    always_comb begin
        inc    = '0;
        inc[0] = 1'b1;
        inc[1] = halt | retire_regwrite | retire_memwrite;
        inc[2] = icache_req;
        inc[3] = icache_req & icache_hit;
        inc[4] = dcache_req;
        inc[5] = dcache_req & dcache_hit;
        inc[6] = stall;
    end

    // An increment from all-ones is the overflow event; the counter then either
    // sticks at all-ones or rolls over depending on SAT.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = '0;
            ovf_d = '0;
        end else if (state_q == ST_RUN) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (inc[i]) begin
                    if (&cnt_q[i]) begin
                        ovf_d[i] = 1'b1;
                        cnt_d[i] = SAT ? cnt_q[i] : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        status_raw = {state_q, 1'b0, ovf_q};
        status_val = CNT_W'(status_raw);
        sel_val    = status_val;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == 3'(i)) sel_val = cnt_q[i];
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? sel_val : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            halted_q   <= 1'b0;
            ovf_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign state    = state_q;
    assign halted   = halted_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench for perf_counter_unit: a 32-bit saturating instance plus two
// 8-bit instances (saturating and wrapping) driven by the same event stimulus.
module tb_perf_counter_unit;

    localparam logic [9:0] EN   = 10'h200;
    localparam logic [9:0] CLR  = 10'h100;
    localparam logic [9:0] HLT  = 10'h080;
    localparam logic [9:0] RR   = 10'h040;
    localparam logic [9:0] RM   = 10'h020;
    localparam logic [9:0] STL  = 10'h010;
    localparam logic [9:0] IREQ = 10'h008;
    localparam logic [9:0] IHIT = 10'h004;
    localparam logic [9:0] DREQ = 10'h002;
    localparam logic [9:0] DHIT = 10'h001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0, clear = 1'b0, retire_regwrite = 1'b0, retire_memwrite = 1'b0;
    logic halt = 1'b0, stall = 1'b0, icache_req = 1'b0, icache_hit = 1'b0;
    logic dcache_req = 1'b0, dcache_hit = 1'b0;
    logic rd_en_a = 1'b0, rd_en_b = 1'b0, rd_en_c = 1'b0;
    logic [2:0] rd_sel = 3'd0;

    logic [31:0] rd_data_a;
    logic [7:0]  rd_data_b, rd_data_c;
    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic [1:0]  state_a, state_b, state_c;
    logic        halted_a, halted_b, halted_c;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_c[$];
    logic [31:0] test2_exp [7];
    logic [9:0]  ev;

    always #5 clk = ~clk;

    perf_counter_unit #(.CNT_W(32), .SAT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .retire_regwrite(retire_regwrite), .retire_memwrite(retire_memwrite),
        .halt(halt), .stall(stall), .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit), .rd_en(rd_en_a), .rd_sel(rd_sel),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .state(state_a), .halted(halted_a)
    );

    perf_counter_unit #(.CNT_W(8), .SAT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .retire_regwrite(retire_regwrite), .retire_memwrite(retire_memwrite),
        .halt(halt), .stall(stall), .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit), .rd_en(rd_en_b), .rd_sel(rd_sel),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .state(state_b), .halted(halted_b)
    );

    perf_counter_unit #(.CNT_W(8), .SAT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .retire_regwrite(retire_regwrite), .retire_memwrite(retire_memwrite),
        .halt(halt), .stall(stall), .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit), .rd_en(rd_en_c), .rd_sel(rd_sel),
        .rd_data(rd_data_c), .rd_valid(rd_valid_c), .state(state_c), .halted(halted_c)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one event pattern for n edges; read strobes last exactly one edge.
    task automatic applyStimulus(input logic [9:0] evt, input int n);
        {enable, clear, halt, retire_regwrite, retire_memwrite, stall,
         icache_req, icache_hit, dcache_req, dcache_hit} = evt;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd_en_a = 1'b0;
            rd_en_b = 1'b0;
            rd_en_c = 1'b0;
        end
    endtask

    task automatic issueRead(input logic [2:0] which, input logic [2:0] sel,
                             input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
        rd_sel = sel;
        if (which[0]) begin rd_en_a = 1'b1; exp_a.push_back(ea); end
        if (which[1]) begin rd_en_b = 1'b1; exp_b.push_back(eb); end
        if (which[2]) begin rd_en_c = 1'b1; exp_c.push_back(ec); end
    endtask

    // Monitor: every presented read result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid_a) begin
            if (exp_a.size() == 0) checkOutput("rd_valid_a_unexpected", 32'(rd_valid_a), 32'd0);
            else checkOutput("rd_data_a", rd_data_a, exp_a.pop_front());
        end
        if (rd_valid_b) begin
            if (exp_b.size() == 0) checkOutput("rd_valid_b_unexpected", 32'(rd_valid_b), 32'd0);
            else checkOutput("rd_data_b", 32'(rd_data_b), exp_b.pop_front());
        end
        if (rd_valid_c) begin
            if (exp_c.size() == 0) checkOutput("rd_valid_c_unexpected", 32'(rd_valid_c), 32'd0);
            else checkOutput("rd_data_c", 32'(rd_data_c), exp_c.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test2_exp = '{32'd9, 32'd0, 32'd6, 32'd3, 32'd4, 32'd4, 32'd2};

        applyStimulus(10'h000, 2);
        checkOutput("reset_rd_data", rd_data_a, 32'd0);
        checkOutput("reset_rd_valid", 32'(rd_valid_a), 32'd0);
        checkOutput("reset_state", 32'(state_a), 32'd0);
        checkOutput("reset_halted", 32'(halted_a), 32'd0);
        rst = 1'b1;

        // Run 10 counted cycles with 4 retiring instructions, then pause
        applyStimulus(EN, 1);
        for (int i = 0; i < 9; i++) begin
            ev = EN;
            if (i == 2) ev = ev | RR | RM;
            else if (i == 0 || i == 4 || i == 6) ev = ev | RR;
            applyStimulus(ev, 1);
        end
        applyStimulus(10'h000, 1);
        checkOutput("pause_state", 32'(state_a), 32'd0);
        applyStimulus(10'h000, 5);
        issueRead(3'b001, 3'd0, 32'd10, 32'd0, 32'd0); applyStimulus(10'h000, 1);
        issueRead(3'b001, 3'd1, 32'd4, 32'd0, 32'd0);  applyStimulus(10'h000, 1);
        issueRead(3'b001, 3'd7, 32'd0, 32'd0, 32'd0);  applyStimulus(10'h000, 1);

        // Read during RUN returns the pre-increment value; rd_data holds afterwards
        applyStimulus(EN, 1);
        checkOutput("resume_state", 32'(state_a), 32'd1);
        issueRead(3'b001, 3'd0, 32'd10, 32'd0, 32'd0); applyStimulus(EN, 1);
        applyStimulus(EN, 1);
        checkOutput("rd_valid_drop", 32'(rd_valid_a), 32'd0);
        checkOutput("rd_data_hold", rd_data_a, 32'd10);
        issueRead(3'b001, 3'd7, 32'h100, 32'd0, 32'd0); applyStimulus(EN, 1);
        issueRead(3'b001, 3'd0, 32'd13, 32'd0, 32'd0);  applyStimulus(CLR | EN, 1);
        checkOutput("clear_state", 32'(state_a), 32'd0);
        issueRead(3'b001, 3'd0, 32'd0, 32'd0, 32'd0);   applyStimulus(10'h000, 1);

        // Cache request/hit and stall counting
        applyStimulus(EN, 1);
        for (int i = 0; i < 8; i++) begin
            ev = EN | DHIT;
            if (i < 6) ev = ev | IREQ;
            if (i < 3) ev = ev | IHIT;
            if (i >= 6) ev = ev | IHIT | STL;
            if (i < 4) ev = ev | DREQ;
            applyStimulus(ev, 1);
        end
        applyStimulus(10'h000, 1);
        for (int s = 0; s < 7; s++) begin
            issueRead(3'b001, 3'(s), test2_exp[s], 32'd0, 32'd0);
            applyStimulus(10'h000, 1);
        end

        // Halt after 7 counted cycles; HALTED ignores events and enable until clear
        applyStimulus(CLR, 1);
        applyStimulus(EN, 1);
        applyStimulus(EN, 7);
        applyStimulus(EN | HLT, 1);
        checkOutput("halt_halted", 32'(halted_a), 32'd1);
        checkOutput("halt_state", 32'(state_a), 32'd2);
        applyStimulus(EN | RR | IREQ | IHIT | STL, 5);
        checkOutput("halt_still_halted", 32'(halted_a), 32'd1);
        issueRead(3'b001, 3'd0, 32'd8, 32'd0, 32'd0);    applyStimulus(10'h000, 1);
        issueRead(3'b001, 3'd1, 32'd1, 32'd0, 32'd0);    applyStimulus(10'h000, 1);
        issueRead(3'b001, 3'd2, 32'd0, 32'd0, 32'd0);    applyStimulus(10'h000, 1);
        issueRead(3'b001, 3'd6, 32'd0, 32'd0, 32'd0);    applyStimulus(10'h000, 1);
        issueRead(3'b001, 3'd7, 32'h200, 32'd0, 32'd0);  applyStimulus(10'h000, 1);
        applyStimulus(CLR, 1);
        checkOutput("unhalt_state", 32'(state_a), 32'd0);
        checkOutput("unhalt_halted", 32'(halted_a), 32'd0);
        issueRead(3'b001, 3'd0, 32'd0, 32'd0, 32'd0);    applyStimulus(10'h000, 1);
        issueRead(3'b001, 3'd7, 32'd0, 32'd0, 32'd0);    applyStimulus(10'h000, 1);

        // 260 counted cycles: 8-bit saturating sticks at 0xFF, wrapping lands on 0x04
        applyStimulus(EN, 1);
        applyStimulus(EN, 259);
        applyStimulus(10'h000, 1);
        checkOutput("sat_state_b", 32'(state_b), 32'd0);
        checkOutput("sat_state_c", 32'(state_c), 32'd0);
        checkOutput("sat_halted_b", 32'(halted_b), 32'd0);
        checkOutput("sat_halted_c", 32'(halted_c), 32'd0);
        issueRead(3'b111, 3'd0, 32'd260, 32'hFF, 32'h04); applyStimulus(10'h000, 1);
        issueRead(3'b111, 3'd7, 32'd0, 32'h01, 32'h01);   applyStimulus(10'h000, 1);
        applyStimulus(EN, 1);
        issueRead(3'b111, 3'd7, 32'h100, 32'h01, 32'h01); applyStimulus(EN, 1);
        applyStimulus(10'h000, 1);

        // Asynchronous reset between edges, then restart only on enable
        applyStimulus(CLR, 1);
        applyStimulus(EN, 1);
        applyStimulus(EN, 3);
        issueRead(3'b001, 3'd0, 32'd3, 32'd0, 32'd0); applyStimulus(EN, 1);
        checkOutput("prereset_state", 32'(state_a), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rd_data", rd_data_a, 32'd0);
        checkOutput("async_rd_valid", 32'(rd_valid_a), 32'd0);
        checkOutput("async_state", 32'(state_a), 32'd0);
        checkOutput("async_halted", 32'(halted_a), 32'd0);
        applyStimulus(10'h000, 1);
        rst = 1'b1;
        applyStimulus(10'h000, 2);
        checkOutput("postreset_state", 32'(state_a), 32'd0);
        issueRead(3'b001, 3'd0, 32'd0, 32'd0, 32'd0); applyStimulus(10'h000, 1);
        applyStimulus(EN, 1);
        applyStimulus(EN, 2);
        issueRead(3'b001, 3'd0, 32'd2, 32'd0, 32'd0); applyStimulus(10'h000, 1);
        applyStimulus(10'h000, 2);

        checkOutput("queue_a_drained", 32'(exp_a.size()), 32'd0);
        checkOutput("queue_b_drained", 32'(exp_b.size()), 32'd0);
        checkOutput("queue_c_drained", 32'(exp_c.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
